// File: rtl/exibe_pkg.sv
// Shared definitions for the sequence display block: state codes and default dwell lengths.
// No logic here.
// No flow control here.
package exibe_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHOW  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } estado_t;

    localparam int ON_CYCLES_DEF  = 1000;
    localparam int OFF_CYCLES_DEF = 500;
    localparam int TW_DEF         = 12;

endpackage

// File: rtl/temporizador_exibicao.sv
// Loadable down-counter for dwell times; terminal is high while the count is zero.
// Latency: load takes effect on the next edge; terminal is combinational from the count.
// No backpressure: counts whenever habilita is high and it is not already at zero.
module temporizador_exibicao #(
    parameter int TW = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          carrega,
    input  logic [TW-1:0] valor,
    input  logic          habilita,
    output logic          terminal
);

    logic [TW-1:0] contagem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (carrega) begin
            contagem <= valor;
        end else if (habilita && (contagem != '0)) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign terminal = (contagem == '0);

endmodule

// File: rtl/exibe_sequencia.sv
// Plays ROM items 0..limite on leds, each lit ON_CYCLES then dark OFF_CYCLES, then pulses fim_exibicao.
// Latency: (limite+1)*(1+ON_CYCLES+OFF_CYCLES) cycles from the start edge to DONE.
// No backpressure: the ROM answers one cycle after endereco settles, covered by the FETCH cycle.
module exibe_sequencia
    import exibe_pkg::*;
#(
    parameter int ON_CYCLES  = ON_CYCLES_DEF,
    parameter int OFF_CYCLES = OFF_CYCLES_DEF,
    parameter int TW         = TW_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancela,
    input  logic [3:0] limite,
    output logic [3:0] endereco,
    input  logic [3:0] dados,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       fim_exibicao,
    output logic [2:0] db_estado
);

    estado_t       estado, prox;
    logic [3:0]    limite_reg;
    logic          carrega, habilita, terminal;
    logic [TW-1:0] valor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= IDLE;
        end else begin
            estado <= prox;
        end
    end

    always_comb begin
        prox = estado;
        unique case (estado)
            IDLE:    if (iniciar) prox = FETCH;
            FETCH:   prox = SHOW;
            SHOW:    if (terminal) prox = GAP;
            GAP:     if (terminal) prox = (endereco == limite_reg) ? DONE : FETCH;
            DONE:    prox = IDLE;
            default: prox = IDLE;
        endcase
        if (cancela) prox = IDLE;
    end

    always_comb begin
        leds         = (estado == SHOW) ? dados : 4'd0;
        ocupado      = (estado != IDLE);
        fim_exibicao = (estado == DONE);
        db_estado    = estado;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco   <= 4'd0;
            limite_reg <= 4'd0;
        end else if (cancela) begin
            endereco <= 4'd0;
        end else if ((estado == IDLE) && iniciar) begin
            endereco   <= 4'd0;
            limite_reg <= limite;
        end else if ((estado == GAP) && terminal && (endereco != limite_reg)) begin
            endereco <= endereco + 4'd1;
        end
    end

    // Reload on every state change with the dwell of the state being entered, minus the entry cycle.
    always_comb begin
        carrega  = (prox != estado);
        habilita = (estado == SHOW) || (estado == GAP);
        case (prox)
            SHOW:    valor = TW'(ON_CYCLES - 1);
            GAP:     valor = TW'(OFF_CYCLES - 1);
            default: valor = '0;
        endcase
    end

    temporizador_exibicao #(
        .TW(TW)
    ) u_temporizador (
        .clock    (clock),
        .reset    (reset),
        .carrega  (carrega),
        .valor    (valor),
        .habilita (habilita),
        .terminal (terminal)
    );

endmodule
